// File: rtl/multi_func_gen_pkg.sv
// rtl/multi_func_gen_pkg.sv - waveform mode codes and sample mapping for multi_func_gen
// Mapping is written for widths up to 32 bits; callers truncate to OUT_W.
package mfg_pkg;

  localparam logic [2:0] MODE_SAW_UP   = 3'd0;
  localparam logic [2:0] MODE_SAW_DOWN = 3'd1;
  localparam logic [2:0] MODE_TRIANGLE = 3'd2;
  localparam logic [2:0] MODE_SQUARE   = 3'd3;
  localparam logic [2:0] MODE_PULSE25  = 3'd4;
  localparam logic [2:0] MODE_STAIR    = 3'd5;
  localparam logic [2:0] MODE_MID      = 3'd6;
  localparam logic [2:0] MODE_ZERO     = 3'd7;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] wave_map(input logic [2:0] mode,
                                           input logic [31:0] p,
                                           input int unsigned w);
    logic [31:0] mask;
    logic [31:0] msb_sh;
    logic [31:0] dbl;
    wave_map = '0;
    mask     = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    msb_sh   = p >> (w - 1);
    dbl      = (p << 1) & mask;
    case (mode)
      MODE_SAW_UP:   wave_map = p & mask;
      MODE_SAW_DOWN: wave_map = ~p & mask;
      MODE_TRIANGLE: wave_map = msb_sh[0] ? (~dbl & mask) : dbl;
      MODE_SQUARE:   wave_map = msb_sh[0] ? mask : '0;
      MODE_PULSE25:  wave_map = (((p >> (w - 2)) & 32'd3) == 32'd0) ? mask : '0;
      MODE_STAIR:    wave_map = p & mask & ~32'd3;
      MODE_MID:      wave_map = 32'd1 << (w - 1);
      default:       wave_map = '0;
    endcase
  endfunction

endpackage

// File: rtl/multi_func_gen_if.sv
// rtl/multi_func_gen_if.sv - configuration write port and per-channel outputs of multi_func_gen
interface multi_func_gen_if #(
  parameter int CHANNELS = 3,
  parameter int DIV_W    = 8,
  parameter int OUT_W    = 8
) ();
  localparam int CH_W = mfg_pkg::ch_w(CHANNELS);

  logic                      cfg_we;
  logic [CH_W-1:0]           cfg_ch;
  logic [DIV_W-1:0]          cfg_pl;
  logic [2:0]                cfg_mode;
  logic                      cfg_en;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS*OUT_W-1:0] out;

  modport master (output cfg_we, cfg_ch, cfg_pl, cfg_mode, cfg_en,
                  input  tick, out);
  modport slave  (input  cfg_we, cfg_ch, cfg_pl, cfg_mode, cfg_en,
                  output tick, out);
endinterface

// File: rtl/mfg_channel.sv
// rtl/mfg_channel.sv - one channel: loadable divider, toggle, phase counter, waveform register
// MFG_WRAP_UPDATE_EN defers config writes to the phase wrap through a shadow register.
module mfg_channel
  import mfg_pkg::*;
#(
  parameter int DIV_W = 8,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_pl,
  input  logic [2:0]       i_mode,
  input  logic             i_en,
  output logic             o_tick,
  output logic [OUT_W-1:0] o_out
);

  logic [DIV_W-1:0] r_pl;
  logic [2:0]       r_mode;
  logic             r_en;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_tgl;
  logic [OUT_W-1:0] r_phase;
  logic [OUT_W-1:0] r_out;
  logic             r_tick;

  logic             w_tc;
  logic             w_step;
  logic             w_load;
  logic [DIV_W-1:0] w_ld_pl;
  logic [2:0]       w_ld_mode;
  logic             w_ld_en;
  logic [OUT_W-1:0] w_wave;

  assign w_tc   = r_en & (&r_div_cnt);
  assign w_step = w_tc & r_tgl;
  assign w_wave = OUT_W'(wave_map(r_mode, 32'(r_phase), OUT_W));

`ifdef MFG_WRAP_UPDATE_EN
  logic [DIV_W-1:0] r_sh_pl;
  logic [2:0]       r_sh_mode;
  logic             r_sh_en;
  logic             r_pend;

  // Commit on the step that wraps phase, or straight away when idle.
  assign w_load    = r_pend & ((w_step & (&r_phase)) | ~r_en);
  assign w_ld_pl   = r_sh_pl;
  assign w_ld_mode = r_sh_mode;
  assign w_ld_en   = r_sh_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_pl   <= '0;
      r_sh_mode <= '0;
      r_sh_en   <= 1'b0;
      r_pend    <= 1'b0;
    end else if (i_wr) begin
      r_sh_pl   <= i_pl;
      r_sh_mode <= i_mode;
      r_sh_en   <= i_en;
      r_pend    <= 1'b1;
    end else if (w_load) begin
      r_pend    <= 1'b0;
    end
  end
`else
  assign w_load    = i_wr;
  assign w_ld_pl   = i_pl;
  assign w_ld_mode = i_mode;
  assign w_ld_en   = i_en;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pl      <= '0;
      r_mode    <= '0;
      r_en      <= 1'b0;
      r_div_cnt <= '0;
      r_tgl     <= 1'b0;
      r_phase   <= '0;
      r_out     <= '0;
      r_tick    <= 1'b0;
    end else begin
      if (w_load) begin
        r_pl      <= w_ld_pl;
        r_mode    <= w_ld_mode;
        r_en      <= w_ld_en;
        r_div_cnt <= w_ld_pl;
        r_tgl     <= 1'b0;
      end else if (r_en) begin
        r_div_cnt <= w_tc ? r_pl : r_div_cnt + 1'b1;
        if (w_tc) begin
          r_tgl <= ~r_tgl;
        end
      end
      // A reload never swallows the phase advance of the same cycle.
      if (w_step) begin
        r_phase <= r_phase + 1'b1;
      end
      r_tick <= w_step;
      if (r_en) begin
        r_out <= w_wave;
      end
    end
  end

  assign o_tick = r_tick;
  assign o_out  = r_out;

endmodule

// File: rtl/multi_func_gen.sv
// rtl/multi_func_gen.sv - N-channel function generator top: write decode and channel array
// Optional MFG_WRAP_UPDATE_EN makes configuration writes take effect at the phase wrap.
module multi_func_gen
  import mfg_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int DIV_W    = 8,
  parameter int OUT_W    = 8
) (
  input logic             clk,
  input logic             rst,
  multi_func_gen_if.slave bus
);

  localparam int CH_W = ch_w(CHANNELS);

  logic [CHANNELS-1:0]       w_tick;
  logic [CHANNELS*OUT_W-1:0] w_out;

  // Channel numbers at or above CHANNELS match no instance, so such writes drop.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic w_wr;
    assign w_wr = bus.cfg_we && (bus.cfg_ch == CH_W'(c));

    mfg_channel #(
      .DIV_W (DIV_W),
      .OUT_W (OUT_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .i_wr   (w_wr),
      .i_pl   (bus.cfg_pl),
      .i_mode (bus.cfg_mode),
      .i_en   (bus.cfg_en),
      .o_tick (w_tick[c]),
      .o_out  (w_out[c*OUT_W +: OUT_W])
    );
  end

  assign bus.tick = w_tick;
  assign bus.out  = w_out;

endmodule

// File: tb/tb_multi_func_gen.sv
// tb/tb_multi_func_gen.sv - randomized bench for multi_func_gen against a cycle-count reference model
module tb_multi_func_gen;

  localparam int CHANNELS = 3;
  localparam int DIV_W    = 8;
  localparam int OUT_W    = 8;
  localparam int NDIV     = 1 << DIV_W;
  localparam int NOUT     = 1 << OUT_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multi_func_gen_if #(.CHANNELS(CHANNELS), .DIV_W(DIV_W), .OUT_W(OUT_W)) bus ();

  multi_func_gen #(.CHANNELS(CHANNELS), .DIV_W(DIV_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_pl[CHANNELS], m_mode[CHANNELS], m_en[CHANNELS];
  int m_rem[CHANNELS], m_phase[CHANNELS], m_out[CHANNELS], m_tick[CHANNELS];
  int s_pl[CHANNELS], s_mode[CHANNELS], s_en[CHANNELS], s_pend[CHANNELS];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_wave(input int mode, input int p);
    case (mode)
      0: return p;
      1: return NOUT - 1 - p;
      2: return (p < NOUT / 2) ? 2 * p : 2 * NOUT - 1 - 2 * p;
      3: return (p >= NOUT / 2) ? NOUT - 1 : 0;
      4: return (p < NOUT / 4) ? NOUT - 1 : 0;
      5: return p - (p % 4);
      6: return NOUT / 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_pl[c] = 0; m_mode[c] = 0; m_en[c] = 0; m_rem[c] = 0;
      m_phase[c] = 0; m_out[c] = 0; m_tick[c] = 0;
      s_pl[c] = 0; s_mode[c] = 0; s_en[c] = 0; s_pend[c] = 0;
    end
  endtask

  // Phase advances once every 2*(NDIV-pl) enabled cycles, counted from the last write.
  task automatic model_edge(input bit we, input int ch, input int pl, input int mode, input int en);
    for (int c = 0; c < CHANNELS; c++) begin
      bit step;
      bit commit;
      int nout;
      step   = (m_en[c] != 0) && (m_rem[c] == 1);
      nout   = (m_en[c] != 0) ? ref_wave(m_mode[c], m_phase[c]) : m_out[c];
      commit = (s_pend[c] != 0) && ((step && m_phase[c] == NOUT - 1) || m_en[c] == 0);
      if (step) begin
        m_phase[c] = (m_phase[c] + 1) % NOUT;
        m_rem[c]   = 2 * (NDIV - m_pl[c]);
      end else if (m_en[c] != 0) begin
        m_rem[c]--;
      end
      m_tick[c] = step ? 1 : 0;
      m_out[c]  = nout;
`ifdef MFG_WRAP_UPDATE_EN
      if (commit) begin
        m_pl[c] = s_pl[c]; m_mode[c] = s_mode[c]; m_en[c] = s_en[c];
        m_rem[c] = 2 * (NDIV - m_pl[c]);
      end
      if (we && ch == c) begin
        s_pl[c] = pl; s_mode[c] = mode; s_en[c] = en; s_pend[c] = 1;
      end else if (commit) begin
        s_pend[c] = 0;
      end
`else
      if (commit) s_pend[c] = 0;
      if (we && ch == c) begin
        m_pl[c] = pl; m_mode[c] = mode; m_en[c] = en;
        m_rem[c] = 2 * (NDIV - pl);
      end
`endif
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < CHANNELS; c++) begin
      check($sformatf("tick%0d", c), 32'(bus.tick[c]), m_tick[c]);
      check($sformatf("out%0d", c), 32'(bus.out[c*OUT_W +: OUT_W]), m_out[c]);
    end
  endtask

  task automatic cycle(input bit we, input int ch, input int pl, input int mode, input int en);
    bus.cfg_we   = we;
    bus.cfg_ch   = ch[1:0];
    bus.cfg_pl   = pl[DIV_W-1:0];
    bus.cfg_mode = mode[2:0];
    bus.cfg_en   = en[0];
    @(posedge clk);
    model_edge(we, ch, pl, mode, en);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #1;
    for (int c = 0; c < CHANNELS; c++) begin
      check("rst_tick", 32'(bus.tick[c]), 32'd0);
      check("rst_out", 32'(bus.out[c*OUT_W +: OUT_W]), 32'd0);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst          = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_pl   = '0;
    bus.cfg_mode = '0;
    bus.cfg_en   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b1;

    cycle(1'b1, 0, 254, 0, 1);
    cycle(1'b1, 1, 250, 3, 1);
    idle(3200);

    cycle(1'b1, 0, 254, 0, 0);
    idle(50);
    cycle(1'b1, 0, 254, 0, 1);
    idle(100);

    cycle(1'b1, 3, 200, 5, 1);
    idle(20);

    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) begin
        pulse_reset();
        idle(10);
      end
      if ($urandom_range(0, 29) == 0) begin
        int pl;
        pl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, NDIV - 1)
                                         : $urandom_range(NDIV - 16, NDIV - 1);
        cycle(1'b1, $urandom_range(0, 3), pl, $urandom_range(0, 7),
              ($urandom_range(0, 3) != 0) ? 1 : 0);
      end else begin
        idle(1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_func_gen.md
# multi_func_gen

Parametrised N-channel function generator with per-channel programmable frequency, the next generation of the single-channel function generator with 3-bit frequency select. Each channel has a loadable up-counting divider with a terminal-count reload, like a 74193 parallel-load chain. A divide-by-2 toggle stage, JK-style, follows the divider, then a phase counter and a waveform mapper. Unlike the previous block, it uses no derived clocks: all channels run on `clk` with single-cycle step enables, and each channel is configured independently through a write port.

## Interface
- `CHANNELS`, default 3: number of independent channels, 1..16.
- `DIV_W`, default 8: divider width; `pl` is the parallel-load value.
- `OUT_W`, default 8: phase counter and output sample width, at least 4.

- `clk`  in  1: sole clock; all state is updated on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `cfg_we`  in  1: configuration write strobe, one cycle.
- `cfg_ch`  in  $clog2(CHANNELS) (min 1): target channel. Writes with values ≥ CHANNELS are ignored.
- `cfg_pl`  in  DIV_W: divider parallel-load value.
- `cfg_mode`  in  3: waveform select.
- `cfg_en`  in  1: channel enable.
- `tick`  out  CHANNELS: per-channel one-cycle pulse marking a phase advance.
- `out`  out  CHANNELS*OUT_W: per-channel sample; channel c occupies bits [c*OUT_W +: OUT_W].

## Operation
- Per-channel state: `pl_r`, `mode_r`, `en_r`, `div_cnt` (DIV_W), `tgl` (1), `phase` (OUT_W), plus registered `tick` and `out`.
- Reset values: all state is 0, so every channel starts disabled with mode 000. All `tick` and `out` outputs are 0.
- When `en_r`=0: `div_cnt`, `tgl`, `phase` and `out` hold their values, and `tick` is 0.
- When `en_r`=1, on each cycle:
  - If `div_cnt` is all-ones: terminal count `tc`=1 and `div_cnt` ← `pl_r`.
  - Otherwise `div_cnt` increments.
- On `tc`: `tgl` inverts. `step` = `tc` and `tgl`=1 (value before the inversion).
- On `step`: `phase` ← `phase`+1, wrapping modulo 2^OUT_W.
- Step period after the first reload is 2·(2^DIV_W − `pl_r`) cycles. With `pl`=all-ones, a step occurs every 2 cycles.
- Waveform from `mode_r` and `phase` (p) when p is registered into `out`:
  - 000: sawtooth up, p.
  - 001: sawtooth down, ~p.
  - 010: triangle. If MSB(p)=0, the output is {p[OUT_W-2:0],0}; otherwise it is ~{p[OUT_W-2:0],0}.
  - 011: square, all bits = MSB(p).
  - 100: 25% pulse, all-ones when p[OUT_W-1:OUT_W-2]=00, else 0.
  - 101: staircase, p with the low 2 bits cleared.
  - 110: mid-scale constant, 1 followed by zeros.
  - 111: zero.
- Config write, macro absent: on the cycle after `cfg_we`, the addressed channel applies the new values immediately:
  - `pl_r`, `mode_r` and `en_r` take the written values.
  - `div_cnt` ← `cfg_pl`, `tgl` ← 0, `phase` is unchanged.
- A write applies only to `cfg_ch`. Other channels are unaffected.

## Timing
- `tick[c]` is registered `step`. It goes high in the cycle in which `phase` shows the incremented value.
- `out[c]` is registered from the current `phase` and `mode_r`. It updates one cycle after `tick[c]`.
- A `mode_r` change is visible on `out` one cycle after it takes effect.
- First period after a write is (2^DIV_W − `pl`) cycles to the first `tc`. The first `step` comes at the second `tc`.
- After reset plus a write that only sets `en`, the divider starts from `cfg_pl`, not from 0.
- If `cfg_we` coincides with `step` on the same channel, the write wins: `div_cnt` and `tgl` are reloaded, and `phase` still increments.
- Assertion of `rst` mid-operation clears all state asynchronously. Deassertion takes effect at the next `clk` edge.

## Configuration
- `MFG_WRAP_UPDATE_EN`, when defined:
  - Each channel gets a shadow {pl, mode, en} plus a pending flag. A write loads the shadow and sets pending; a later write before commit overwrites the shadow.
  - The shadow commits to the active registers on the `step` in which `phase` wraps from all-ones to 0, or on the next cycle if the channel is disabled. Commit reloads `div_cnt` ← `pl` and clears `tgl`.
  - This gives glitch-free changes at period boundaries.
- Not defined: immediate update as described in Operation, with no shadow registers.

## Structure
- Package `mfg_pkg` holds the localparam codes for the waveform modes (`MODE_SAW_UP` … `MODE_ZERO`) and the waveform-mapping function, parametrised by OUT_W.
- Sub-module `mfg_channel` contains the divider, toggle, phase counter, waveform mapping and the optional shadow registers. The top level holds the address decode and a generate loop over CHANNELS.

## Test plan
- Defaults, write ch0 pl=254, mode=000, en=1 → `tick[0]` every 4 cycles. `out[0]` reads 1, 2, 3 …, each value one cycle after its tick, and wraps 255→0.
- ch1 pl=250, mode=011 → `out[1]` is 0x00 for 128 ticks, then 0xFF for 128 ticks. The tick period is 12 cycles; ch0 and ch2 are unaffected.
- Write ch0 en=0 mid-run, wait 50 cycles, then write en=1 with pl=254 → `phase` and `out` are frozen while disabled and resume from the held value.
- `cfg_ch`=3 with CHANNELS=3 → no channel state changes.
- Pull `rst` low mid-run → all `out`/`tick` are 0 immediately. After release, channels stay disabled until written.
- With `MFG_WRAP_UPDATE_EN`, change ch0 mode 000→001 at phase 100 → `out` stays sawtooth up until the wrap, then becomes 0xFF, 0xFE, ….
